// File: rtl/i2s_source_ctrl_pkg.sv
// Shared encodings for the 701ES I2S source scheduler: FSM states, source ids,
// Fs class codes and the constant functions that build the Fs class windows.
`timescale 1ns/1ps
package i2s_src_ctrl_pkg;

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_SETTLE  = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    localparam logic SRC_AES = 1'b0;
    localparam logic SRC_EXT = 1'b1;

    typedef enum logic [1:0] {
        FS_UNKNOWN = 2'd0,
        FS_32K     = 2'd1,
        FS_44K1    = 2'd2,
        FS_48K     = 2'd3
    } fs_class_e;

    localparam int FRAME_W = 8;

    function automatic int unsigned fs_nominal(input int unsigned mck_hz, input int unsigned fs_hz);
        return mck_hz / fs_hz;
    endfunction

    // Window is +/-1% of the nominal LRCK period in mck cycles.
    function automatic int unsigned fs_lo(input int unsigned mck_hz, input int unsigned fs_hz);
        return fs_nominal(mck_hz, fs_hz) - fs_nominal(mck_hz, fs_hz) / 100;
    endfunction

    function automatic int unsigned fs_hi(input int unsigned mck_hz, input int unsigned fs_hz);
        return fs_nominal(mck_hz, fs_hz) + fs_nominal(mck_hz, fs_hz) / 100;
    endfunction

endpackage

// File: rtl/i2s_source_ctrl_meter.sv
// LRCK period meter: 2-flop synchroniser, rising-edge detect, saturating
// period counter and alive flag for one asynchronous LRCK input.
`timescale 1ns/1ps
module lrck_period_meter #(
    parameter int PERIOD_W = 12,
    parameter int TIMEOUT  = 4095
) (
    input  logic                i_mck,
    input  logic                i_reset_n,
    input  logic                i_lrck,
    output logic                o_edge,
    output logic [PERIOD_W-1:0] o_sample,
    output logic                o_alive
);

    localparam logic [PERIOD_W-1:0] LP_TIMEOUT = PERIOD_W'(TIMEOUT);

    logic [1:0]          r_sync;
    logic                r_prev;
    logic                r_seen;
    logic [PERIOD_W-1:0] r_cnt;
    logic                w_edge;

    always_ff @(posedge i_mck or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_lrck};
            r_prev <= r_sync[1];
        end
    end

    assign w_edge = r_sync[1] & ~r_prev;

    // Restarting at 1 makes the value seen at the next edge equal the full period.
    always_ff @(posedge i_mck or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt  <= '0;
            r_seen <= 1'b0;
        end else if (w_edge) begin
            r_cnt  <= PERIOD_W'(1);
            r_seen <= 1'b1;
        end else if (r_cnt != LP_TIMEOUT) begin
            r_cnt  <= r_cnt + PERIOD_W'(1);
        end
    end

    assign o_edge   = w_edge;
    assign o_sample = r_cnt;
    assign o_alive  = r_seen & (r_cnt != LP_TIMEOUT);

endmodule

// File: rtl/i2s_source_ctrl.sv
// 701ES I2S source scheduler and lock sequencer. Optional Fs classification
// is built only when the FS_CLASS_EN macro is defined.
`timescale 1ns/1ps
module i2s_source_ctrl
    import i2s_src_ctrl_pkg::*;
#(
    parameter int          PERIOD_W    = 12,
    parameter int          TOL         = 4,
    parameter int          LOCK_FRAMES = 8,
    parameter int          MUTE_FRAMES = 16,
    parameter int          TIMEOUT     = 4095,
    parameter int unsigned MCK_HZ      = 24576000
) (
    input  logic                mck,
    input  logic                reset_n,
    input  logic                aes_active,
    input  logic                aes_lrck,
    input  logic                ext_lrck,
    input  logic                prefer_ext,
    output logic                src_sel,
    output logic                conv_rst_n,
    output logic                mute,
    output logic                locked,
    output logic [PERIOD_W-1:0] fs_period,
    output logic                fs_change,
    output logic [1:0]          fs_class
);

    if (TIMEOUT > (1 << PERIOD_W) - 1 || MCK_HZ == 0) begin : g_bad_params
        $error("i2s_source_ctrl: TIMEOUT exceeds period counter range or MCK_HZ is zero");
    end

    logic                w_aes_edge, w_aes_alive, w_ext_edge, w_ext_alive;
    logic [PERIOD_W-1:0] w_aes_sample, w_ext_sample;

    lrck_period_meter #(.PERIOD_W(PERIOD_W), .TIMEOUT(TIMEOUT)) u_aes_meter (
        .i_mck(mck), .i_reset_n(reset_n), .i_lrck(aes_lrck),
        .o_edge(w_aes_edge), .o_sample(w_aes_sample), .o_alive(w_aes_alive)
    );

    lrck_period_meter #(.PERIOD_W(PERIOD_W), .TIMEOUT(TIMEOUT)) u_ext_meter (
        .i_mck(mck), .i_reset_n(reset_n), .i_lrck(ext_lrck),
        .o_edge(w_ext_edge), .o_sample(w_ext_sample), .o_alive(w_ext_alive)
    );

    logic w_aes_elig, w_ext_elig, w_have, w_pick;

    assign w_ext_elig = w_ext_alive;
    assign w_aes_elig = aes_active & w_aes_alive;
    assign w_have     = w_ext_elig | w_aes_elig;
    assign w_pick     = (prefer_ext & w_ext_elig) ? SRC_EXT :
                        (w_aes_elig ? SRC_AES : (w_ext_elig ? SRC_EXT : SRC_AES));

    logic [1:0]          r_state, w_next;
    logic                r_src_sel;
    logic [PERIOD_W-1:0] r_ref, r_fs_period;
    logic                r_ref_valid;
    logic [FRAME_W-1:0]  r_frames;
    logic                r_conv_rst_n, r_mute, r_locked, r_fs_change;

    logic                w_edge, w_in_tol, w_exit, w_latch, w_fs_chg;
    logic [PERIOD_W-1:0] w_sample, w_cmp, w_diff;

    assign w_edge   = (r_src_sel == SRC_EXT) ? w_ext_edge   : w_aes_edge;
    assign w_sample = (r_src_sel == SRC_EXT) ? w_ext_sample : w_aes_sample;
    assign w_cmp    = (r_state == ST_RUN) ? r_fs_period : r_ref;
    assign w_diff   = (w_sample >= w_cmp) ? (w_sample - w_cmp) : (w_cmp - w_sample);
    assign w_in_tol = (w_diff <= PERIOD_W'(TOL));
    // The pick can only differ from the current source if that source died or lost priority.
    assign w_exit   = ~w_have | (w_pick != r_src_sel);

    always_comb begin
        w_next   = r_state;
        w_latch  = 1'b0;
        w_fs_chg = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_have) w_next = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (w_exit) begin
                    w_next = ST_SEARCH;
                end else if (w_edge && r_ref_valid && w_in_tol &&
                             r_frames == FRAME_W'(LOCK_FRAMES - 1)) begin
                    w_next  = ST_SETTLE;
                    w_latch = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (w_exit) begin
                    w_next = ST_SEARCH;
                end else if (w_edge && r_frames == FRAME_W'(MUTE_FRAMES - 1)) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_exit) begin
                    w_next = ST_SEARCH;
                end else if (w_edge && !w_in_tol) begin
                    w_next   = ST_MEASURE;
                    w_fs_chg = 1'b1;
                end
            end
            default: w_next = ST_SEARCH;
        endcase
    end

    always_ff @(posedge mck or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_SEARCH;
            r_src_sel   <= SRC_AES;
            r_ref       <= '0;
            r_ref_valid <= 1'b0;
            r_frames    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_SEARCH: begin
                    if (w_have) begin
                        r_src_sel   <= w_pick;
                        r_ref_valid <= 1'b0;
                        r_frames    <= '0;
                    end
                end
                ST_MEASURE: begin
                    if (!w_exit && w_edge) begin
                        if (w_latch) begin
                            r_frames <= '0;
                        end else if (r_ref_valid && w_in_tol) begin
                            r_frames <= r_frames + FRAME_W'(1);
                        end else begin
                            r_ref       <= w_sample;
                            r_ref_valid <= 1'b1;
                            r_frames    <= '0;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (!w_exit && w_edge) r_frames <= r_frames + FRAME_W'(1);
                end
                ST_RUN: begin
                    if (w_fs_chg) begin
                        r_ref       <= w_sample;
                        r_ref_valid <= 1'b1;
                        r_frames    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs follow the next state so they settle one cycle after the causing event.
    always_ff @(posedge mck or negedge reset_n) begin
        if (!reset_n) begin
            r_conv_rst_n <= 1'b0;
            r_mute       <= 1'b1;
            r_locked     <= 1'b0;
            r_fs_change  <= 1'b0;
            r_fs_period  <= '0;
        end else begin
            r_conv_rst_n <= (w_next == ST_SETTLE) || (w_next == ST_RUN);
            r_mute       <= (w_next != ST_RUN);
            r_locked     <= (w_next == ST_RUN);
            r_fs_change  <= w_fs_chg;
            if (w_latch) r_fs_period <= r_ref;
        end
    end

`ifdef FS_CLASS_EN
    localparam logic [31:0] LO_32K = fs_lo(MCK_HZ, 32000);
    localparam logic [31:0] HI_32K = fs_hi(MCK_HZ, 32000);
    localparam logic [31:0] LO_44K = fs_lo(MCK_HZ, 44100);
    localparam logic [31:0] HI_44K = fs_hi(MCK_HZ, 44100);
    localparam logic [31:0] LO_48K = fs_lo(MCK_HZ, 48000);
    localparam logic [31:0] HI_48K = fs_hi(MCK_HZ, 48000);

    logic [31:0] w_ref_ext;
    logic [1:0]  w_class, r_fs_class;

    assign w_ref_ext = 32'(r_ref);

    always_comb begin
        w_class = FS_UNKNOWN;
        if (w_ref_ext >= LO_48K && w_ref_ext <= HI_48K)      w_class = FS_48K;
        else if (w_ref_ext >= LO_44K && w_ref_ext <= HI_44K) w_class = FS_44K1;
        else if (w_ref_ext >= LO_32K && w_ref_ext <= HI_32K) w_class = FS_32K;
    end

    always_ff @(posedge mck or negedge reset_n) begin
        if (!reset_n) begin
            r_fs_class <= FS_UNKNOWN;
        end else if (w_latch) begin
            r_fs_class <= w_class;
        end else if (w_next == ST_SEARCH || w_next == ST_MEASURE) begin
            r_fs_class <= FS_UNKNOWN;
        end
    end

    assign fs_class = r_fs_class;
`else
    assign fs_class = FS_UNKNOWN;
`endif

    assign src_sel    = r_src_sel;
    assign conv_rst_n = r_conv_rst_n;
    assign mute       = r_mute;
    assign locked     = r_locked;
    assign fs_period  = r_fs_period;
    assign fs_change  = r_fs_change;

endmodule

// File: doc/i2s_source_ctrl.md
Name: i2s_source_ctrl

Overview:
Source scheduler and lock sequencer for the 701ES output path. Chooses between the aes3_rx I2S stream and the external I2S stream, and measures the LRCK period in mck cycles. Sequences the I2S_to_16LJ32fs converter reset and the output mute so that source changes, Fs changes and signal loss always pass through a clean mute/relock cycle. Sits in direct_701ES between the two I2S sources and the converter/output_701ES chain; drives the source mux select.

Parameters:
PERIOD_W, 12, width of the LRCK period counter in mck cycles
TOL, 4, allowed period deviation (mck cycles) still counted as the same Fs
LOCK_FRAMES, 8, consecutive in-tolerance LRCK periods required to declare the rate stable
MUTE_FRAMES, 16, LRCK periods mute is held after converter reset release
TIMEOUT, 4095, mck cycles without an LRCK rising edge that declares a source dead (must be <= 2^PERIOD_W-1)
MCK_HZ, 24576000, mck frequency; used only by FS_CLASS_EN

Ports:
mck  in  1  system clock, single clock domain
reset_n  in  1  asynchronous active-low reset
aes_active  in  1  aes3_rx active flag (already in mck domain)
aes_lrck  in  1  aes3_rx LRCK (asynchronous)
ext_lrck  in  1  external LRCK (asynchronous)
prefer_ext  in  1  1 = external source has priority
src_sel  out  1  0 = aes3_rx, 1 = external
conv_rst_n  out  1  active-low reset to the converter
mute  out  1  1 = force APT/data mute downstream
locked  out  1  1 = state RUN
fs_period  out  PERIOD_W  locked LRCK period in mck cycles
fs_change  out  1  one-cycle pulse on detected Fs change in RUN
fs_class  out  2  0 unknown, 1 32k, 2 44.1k, 3 48k (see Optional Feature)

Behaviour:
- Reset values (asynchronous): src_sel=0, conv_rst_n=0, mute=1, locked=0, fs_period=0, fs_change=0, fs_class=0, state=SEARCH.
- Each LRCK is synchronised with 2 flops, then rising-edge detected. The period counter clears on each edge and saturates at TIMEOUT. Alive means an edge has occurred within TIMEOUT cycles. The counter value at an edge is the period sample.
- ext eligible = ext alive. aes eligible = aes_active and aes alive.
- Selection rule: if prefer_ext and ext eligible, choose ext; else if aes eligible, choose aes; else if ext eligible, choose ext; else no source.
- States:
  - SEARCH: conv_rst_n=0, mute=1. When a source is chosen, set src_sel and go to MEASURE; the ref period is taken from the next edge.
  - MEASURE: conv_rst_n=0, mute=1. At each edge, compare the sample with ref. Within TOL: count++. Otherwise: ref=sample, count=0. When count reaches LOCK_FRAMES, latch fs_period=ref, go to SETTLE.
  - SETTLE: conv_rst_n=1, mute=1. After MUTE_FRAMES edges, go to RUN.
  - RUN: mute=0, locked=1. A sample with |sample-fs_period| > TOL causes fs_change=1 for one cycle and a transition to MEASURE with ref=sample.
- Exits to SEARCH (from MEASURE, SETTLE or RUN):
  - the selected source loses eligibility, or
  - the selection rule now picks the other source (e.g. prefer_ext rises while ext is eligible).
- All outputs are registered. mute, conv_rst_n and locked change on the cycle after the edge or timeout that caused the transition.
- Priority when events coincide: reset > loss/reselect > Fs change > frame counting.
- src_sel changes only on entry to MEASURE from SEARCH, never while conv_rst_n=1.
- fs_period holds its value outside RUN/SETTLE, until the next latch.

Optional Feature:
FS_CLASS_EN.
- Defined: fs_class is registered at latch time from fs_period against MCK_HZ/32000, MCK_HZ/44100 and MCK_HZ/48000, each with a ±1% window computed by constant functions; no match gives 0. fs_class is cleared to 0 on leaving RUN/SETTLE.
- Undefined: fs_class is tied to 0 and no compare logic is built.

Decomposition:
- Package i2s_src_ctrl_pkg: state encoding (SEARCH, MEASURE, SETTLE, RUN), SRC_AES=0 and SRC_EXT=1 constants, Fs class codes.
- Sub-module lrck_period_meter: synchroniser, edge detect, saturating period counter, alive flag. It is instantiated twice (aes_lrck, ext_lrck); the controller uses the selected meter's edge and sample.

Test Plan:
1. mck 24.576 MHz, ext_lrck 48 kHz, aes_active=0 -> src_sel=1. conv_rst_n rises after 9 edges (ref edge + 8). mute falls 16 edges later. fs_period=512, locked=1, fs_class=3 with FS_CLASS_EN.
2. In RUN, ext_lrck changes to 44.1 kHz (period 557) -> fs_change pulses one cycle after the first 557 sample; mute=1, conv_rst_n=0 next cycle; relock gives fs_period=557, fs_class=2.
3. In RUN, ext_lrck stops -> 4095 cycles after the last edge: locked=0, mute=1, conv_rst_n=0, state SEARCH.
4. Both sources eligible, prefer_ext=0 -> src_sel=0 and RUN. Raise prefer_ext -> SEARCH, then src_sel=1 with a full mute/relock sequence.
5. ext period jitter 509..515 -> no fs_change. A single 506 sample -> fs_change=1, relock.
6. Pull reset_n low mid-SETTLE -> all outputs take reset values immediately without mck. Release -> sequence restarts from SEARCH.
